acc_ctrl: RTL and testbench
===========================

Name: acc_ctrl

Overview:
- Sequencer for the myfilter accumulator (acc). One FIR output is computed per accepted input sample.
- Per sample it stores the sample in an external circular sample buffer, then walks TAPS taps, driving sample and coefficient read addresses.
- It issues acc_cmd_t commands delayed to line up with the external multiplier pipeline, then captures acc ext_out and presents it on a valid/ready output.
- Sits between the input stream interface and the acc/multiplier datapath.

Parameters:
- TAPS, 8, number of filter taps (>=2, need not be a power of two).
- MUL_LAT, 1, register stages in the external multiplier (>=0).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATABITS  input sample.
- flush  in  1  request to zero the sample buffer.
- smp_addr  out  AW  sample buffer address; AW = $clog2(TAPS).
- smp_we  out  1  sample buffer write enable.
- smp_wdata  out  DATABITS  sample buffer write data.
- coef_addr  out  AW  coefficient ROM address (tap index).
- cmd_out  out  acc_cmd_t  command to acc cmd_in.
- ext_out  in  DATABITS  acc rounded/saturated output.
- out_valid  out  1  filter result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATABITS  filter result.

Behaviour:
- Reset:
  - state IDLE; wr_ptr = 0; tap counter = 0; command pipe filled with ACC_NOP.
  - out_valid = 0, out_data = 0, smp_we = 0, cmd_out = ACC_NOP.
  - in_ready = 0 while rst is high.
- Memory read latency: sample buffer and ROM are synchronous read, 1 cycle. D = 1 + MUL_LAT.
- in_ready = (state == IDLE) && !flush. A sample is accepted when in_valid && in_ready.
- States:
  - IDLE:
    - flush -> FLUSH. flush has priority over in_valid in the same cycle.
    - Otherwise, accept -> LOAD, and in_data is registered.
  - LOAD (1 cycle):
    - smp_we = 1, smp_addr = wr_ptr, smp_wdata = registered sample.
    - newest <= wr_ptr; wr_ptr <= wr_ptr + 1 with wrap at TAPS-1 -> 0.
    - Next state MAC.
  - MAC (TAPS cycles, k = 0..TAPS-1):
    - coef_addr = k; smp_addr = (newest - k) mod TAPS, with explicit wrap.
    - The command issued is ACC_LOAD for k = 0 and ACC_ADD otherwise.
    - The command enters the D-stage command pipe; cmd_out is the pipe output.
    - After k = TAPS-1 -> DRAIN.
  - DRAIN (D cycles): ACC_NOP is issued. The last ACC_ADD reaches acc in the last DRAIN cycle. Next state RES.
  - RES (1 cycle): out_data <= ext_out; out_valid <= 1. Next state WAIT.
  - WAIT: out_valid and out_data are held stable until out_ready.
    - On out_valid && out_ready: out_valid <= 0, go to IDLE.
    - in_ready is 1 in the following cycle.
  - FLUSH (TAPS cycles): smp_we = 1, smp_wdata = 0, smp_addr = 0..TAPS-1. Then wr_ptr <= 0, go to IDLE.
- Command pipe:
  - Every cycle outside MAC pushes ACC_NOP, so acc only sees ACC_NOP between samples.
- Latency, with accept at cycle 0:
  - cmd_out is non-NOP in cycles 2+D .. TAPS+1+D.
  - out_valid rises at cycle TAPS+3+D.
  - Throughput: one sample per TAPS+4+D cycles when out_ready is held high.
- flush outside IDLE is ignored and is not remembered.
- Reset in any state:
  - Aborts the current operation and flushes the pipe to ACC_NOP in the next cycle.
  - Drops any pending result.
  - Buffer contents are not cleared.

Decomposition:
- Constants in myfilter_pkg: DATABITS, ACCBITS, TAPS, MUL_LAT, CLK_PERIOD.
- Typedefs in myfilter_pkg:
  - acc_cmd_t, including ACC_NOP, ACC_LOAD and ACC_ADD.
  - acc_ctrl_state_t {IDLE, LOAD, MAC, DRAIN, RES, WAIT, FLUSH}.
- Sub-module: acc_cmd_pipe, a parameterised depth-D register chain of acc_cmd_t that resets to ACC_NOP.

Test Plan (TAPS=8, MUL_LAT=1, D=2):
- Reset: hold rst for 2 cycles -> out_valid = 0 and cmd_out = ACC_NOP during reset. In the first cycle after release, in_ready = 1.
- Single sample 0x0100 accepted at cycle 0:
  - smp_we at cycle 1, address 0.
  - cmd_out = ACC_LOAD at cycle 4, ACC_ADD in cycles 5..11, ACC_NOP from cycle 12.
  - out_valid at cycle 13; out_data = ext_out sampled at cycle 12.
- Address walk:
  - First sample writes address 0 and reads smp_addr 0,7,6,5,4,3,2,1 with coef_addr 0..7.
  - Second sample writes address 1 and reads 1,0,7,...,2.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_valid and out_data stay stable and in_ready = 0. When out_ready goes high, the next cycle is IDLE with in_ready = 1.
- flush and in_valid asserted in the same IDLE cycle:
  - in_ready = 0; 8 zero writes to addresses 0..7; wr_ptr = 0.
  - The held in_valid is accepted afterwards, and that sample is written at address 0.
- rst asserted during MAC at k = 3 -> cmd_out = ACC_NOP from the next cycle, out_valid stays 0, wr_ptr = 0, state IDLE.

Source files
------------

// File: rtl/myfilter_pkg.sv
// Shared constants, command/state encodings and address helper for the myfilter
// accumulator sequencer.
package myfilter_pkg;

  localparam int DATABITS   = 16;
  localparam int ACCBITS    = 40;
  localparam int TAPS       = 8;
  localparam int MUL_LAT    = 1;
  localparam int CLK_PERIOD = 10;

  typedef enum logic [1:0] {
    ACC_NOP  = 2'd0,
    ACC_LOAD = 2'd1,
    ACC_ADD  = 2'd2
  } acc_cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    RES   = 3'd4,
    WAIT  = 3'd5,
    FLUSH = 3'd6
  } acc_ctrl_state_t;

  // Circular-buffer slot holding the sample k steps older than 'newest'.
  // The wrap is explicit so a non-power-of-two tap count still indexes correctly.
  function automatic int tap_addr(input int newest, input int k, input int taps);
    if (k > newest) begin
      return newest + taps - k;
    end
    return newest - k;
  endfunction

endpackage

// File: rtl/acc_cmd_pipe.sv
// Depth-configurable register chain that delays acc commands so they line up
// with the multiplier output; every stage resets to ACC_NOP.
module acc_cmd_pipe
  import myfilter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  acc_cmd_t cmd_i,
  output acc_cmd_t cmd_o
);

  acc_cmd_t pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= ACC_NOP;
      end
    end else begin
      pipe_q[0] <= cmd_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign cmd_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/acc_ctrl.sv
// Per-sample sequencer: stores the sample, walks the taps issuing delayed acc
// commands, then captures the acc result behind a valid/ready output.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. in_ready
// is high only in IDLE without flush; out_valid, once raised, holds out_data
// stable until out_ready is seen high.
module acc_ctrl #(
  parameter int TAPS    = myfilter_pkg::TAPS,
  parameter int MUL_LAT = myfilter_pkg::MUL_LAT,
  localparam int AW     = $clog2(TAPS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [myfilter_pkg::DATABITS-1:0] in_data,
  input  logic                              flush,
  output logic [AW-1:0]                     smp_addr,
  output logic                              smp_we,
  output logic [myfilter_pkg::DATABITS-1:0] smp_wdata,
  output logic [AW-1:0]                     coef_addr,
  output myfilter_pkg::acc_cmd_t            cmd_out,
  input  logic [myfilter_pkg::DATABITS-1:0] ext_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [myfilter_pkg::DATABITS-1:0] out_data,
  output myfilter_pkg::acc_ctrl_state_t     dbg_state
);
  import myfilter_pkg::*;

  localparam int D  = 1 + MUL_LAT;
  localparam int DW = (D > 1) ? $clog2(D) : 1;

  acc_ctrl_state_t     state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       newest_q, newest_d;
  logic [AW-1:0]       k_q, k_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [DATABITS-1:0] sample_q, sample_d;
  logic [DATABITS-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  acc_cmd_t            cmd_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      sample_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      newest_q    <= newest_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      sample_q    <= sample_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    newest_d    = newest_q;
    k_d         = k_q;
    drain_d     = drain_q;
    sample_d    = sample_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cmd_issue   = ACC_NOP;
    smp_we      = 1'b0;
    smp_addr    = '0;
    smp_wdata   = '0;
    coef_addr   = '0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          k_d     = '0;
          state_d = FLUSH;
        end else if (in_valid) begin
          sample_d = in_data;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        smp_we    = 1'b1;
        smp_addr  = wr_ptr_q;
        smp_wdata = sample_q;
        newest_d  = wr_ptr_q;
        wr_ptr_d  = (wr_ptr_q == AW'(TAPS-1)) ? '0 : wr_ptr_q + AW'(1);
        k_d       = '0;
        state_d   = MAC;
      end
      MAC: begin
        coef_addr = k_q;
        smp_addr  = AW'(tap_addr(int'(newest_q), int'(k_q), TAPS));
        cmd_issue = (k_q == '0) ? ACC_LOAD : ACC_ADD;
        if (k_q == AW'(TAPS-1)) begin
          k_d     = '0;
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      DRAIN: begin
        // The final ACC_ADD is still in the pipe; wait for it to reach acc.
        if (drain_q == DW'(D-1)) begin
          state_d = RES;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      RES: begin
        out_data_d  = ext_out;
        out_valid_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      FLUSH: begin
        smp_we    = 1'b1;
        smp_addr  = k_q;
        smp_wdata = '0;
        if (k_q == AW'(TAPS-1)) begin
          k_d      = '0;
          wr_ptr_d = '0;
          state_d  = IDLE;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  acc_cmd_pipe #(
    .DEPTH (D)
  ) u_cmd_pipe (
    .clk   (clk),
    .rst   (rst),
    .cmd_i (cmd_issue),
    .cmd_o (cmd_out)
  );

  assign in_ready  = (state_q == IDLE) && !flush && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl with TAPS=8, MUL_LAT=1 (D=2): reset, latency,
// address walk, backpressure, flush priority and mid-MAC reset.
module tb_acc_ctrl;
  import myfilter_pkg::*;

  localparam int TB_TAPS = 8;
  localparam int AW      = 3;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DATABITS-1:0] in_data;
  logic                flush;
  logic [AW-1:0]       smp_addr;
  logic                smp_we;
  logic [DATABITS-1:0] smp_wdata;
  logic [AW-1:0]       coef_addr;
  acc_cmd_t            cmd_out;
  logic [DATABITS-1:0] ext_out;
  logic                out_valid;
  logic                out_ready;
  logic [DATABITS-1:0] out_data;
  acc_ctrl_state_t     dbg_state;

  always #(CLK_PERIOD/2) clk = ~clk;

  acc_ctrl #(
    .TAPS    (TB_TAPS),
    .MUL_LAT (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .smp_addr  (smp_addr),
    .smp_we    (smp_we),
    .smp_wdata (smp_wdata),
    .coef_addr (coef_addr),
    .cmd_out   (cmd_out),
    .ext_out   (ext_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [DATABITS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; ext_out carries a cycle-stamped value so the capture
  // cycle of out_data is visible in the result.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ext_out = 16'h1000 + 16'(cyc);
  endtask

  // Present one sample in the current IDLE cycle (cycle 0) and follow it to
  // the handshake. wa = expected write address, stall = cycles of out_ready low.
  task automatic run_sample(input logic [DATABITS-1:0] data, input int wa, input int stall);
    logic [DATABITS-1:0] exp_res;
    acc_cmd_t            exp_cmd;
    cyc       = 0;
    ext_out   = 16'h1000;
    in_valid  = 1'b1;
    in_data   = data;
    out_ready = 1'b1;
    check("accept_in_ready", in_ready, 1);
    exp_q.push_back(16'h100C);
    step();
    in_valid = 1'b0;
    check("load_state", dbg_state, LOAD);
    check("load_we", smp_we, 1);
    check("load_addr", smp_addr, wa);
    check("load_wdata", smp_wdata, data);
    for (int c = 2; c <= 13; c++) begin
      if (c == 13) out_ready = (stall == 0);
      step();
      if (c <= 9) begin
        check("mac_smp_addr", smp_addr, (wa - (c - 2) + TB_TAPS) % TB_TAPS);
        check("mac_coef_addr", coef_addr, c - 2);
        check("mac_we", smp_we, 0);
      end
      if (c == 4)                 exp_cmd = ACC_LOAD;
      else if (c >= 5 && c <= 11) exp_cmd = ACC_ADD;
      else                        exp_cmd = ACC_NOP;
      check("cmd_out", cmd_out, exp_cmd);
      check("out_valid", out_valid, (c == 13) ? 1 : 0);
      check("busy_in_ready", in_ready, 0);
      if (c == 13) begin
        exp_res = exp_q.pop_front();
        check("out_data", out_data, exp_res);
      end
    end
    for (int s = 1; s <= stall; s++) begin
      step();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_res);
      check("hold_in_ready", in_ready, 0);
      if (s == stall) out_ready = 1'b1;
    end
    step();
    check("post_state", dbg_state, IDLE);
    check("post_in_ready", in_ready, 1);
    check("post_valid", out_valid, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    ext_out   = '0;

    // Reset held for two cycles.
    step();
    check("rst_valid", out_valid, 0);
    check("rst_cmd", cmd_out, ACC_NOP);
    check("rst_in_ready", in_ready, 0);
    check("rst_we", smp_we, 0);
    step();
    check("rst_valid2", out_valid, 0);
    check("rst_cmd2", cmd_out, ACC_NOP);
    check("rst_out_data", out_data, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    #1;
    check("release_in_ready", in_ready, 1);

    // First sample at address 0, second at 1 with 5 cycles of backpressure.
    run_sample(16'h0100, 0, 0);
    run_sample(16'h0200, 1, 5);

    // flush wins over a simultaneous in_valid.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0300;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    for (int f = 0; f < TB_TAPS; f++) begin
      check("flush_state", dbg_state, FLUSH);
      check("flush_we", smp_we, 1);
      check("flush_addr", smp_addr, f);
      check("flush_wdata", smp_wdata, 0);
      check("flush_in_ready", in_ready, 0);
      step();
    end
    check("flush_done_state", dbg_state, IDLE);
    run_sample(16'h0300, 0, 0);

    // Reset during MAC at k = 3 (sample would write address 1).
    in_valid = 1'b1;
    in_data  = 16'h0400;
    step();
    in_valid = 1'b0;
    check("abort_load_addr", smp_addr, 1);
    step();
    step();
    step();
    step();
    check("abort_k3_coef", coef_addr, 3);
    rst = 1'b1;
    step();
    check("abort_cmd", cmd_out, ACC_NOP);
    check("abort_valid", out_valid, 0);
    check("abort_state", dbg_state, IDLE);
    check("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_cmd", cmd_out, ACC_NOP);
      check("idle_valid", out_valid, 0);
    end
    run_sample(16'h0500, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(CLK_PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
